// File: rtl/selector14_dist_pkg.sv
// ---------------------------------------------------------------------------
// selector14_dist_pkg
// Shared constants for the 1-to-4 registered distributor:
//   WIDTH_DEF  default data width of the input and of each channel
//   NCH        number of output channels
//   CH0..CH3   2-bit channel select encodings ({iS1,iS0} / round-robin ptr)
// ---------------------------------------------------------------------------
package selector14_dist_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int NCH       = 4;

    localparam logic [1:0] CH0 = 2'b00;
    localparam logic [1:0] CH1 = 2'b01;
    localparam logic [1:0] CH2 = 2'b10;
    localparam logic [1:0] CH3 = 2'b11;

    // Next round-robin position; the 2-bit add wraps 3 -> 0 naturally.
    function automatic logic [1:0] rr_next(input logic [1:0] ptr);
        return ptr + 2'd1;
    endfunction

endpackage

// File: rtl/selector14_dist_chan.sv
// ---------------------------------------------------------------------------
// sel_chan_reg
// Single-entry channel holding register with a valid/ready handshake.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        write din into the register this cycle (caller guarantees
//               the slot is free or being drained in the same cycle)
//   din         word to load
//   rdy         consumer accepts the held word this cycle
//   dout        held word (kept after drain, only replaced on load)
//   vld         register holds a word not yet taken by the consumer
// ---------------------------------------------------------------------------
module sel_chan_reg
    import selector14_dist_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             rdy,
    output logic [WIDTH-1:0] dout,
    output logic             vld
);

    logic [WIDTH-1:0] dout_d, dout_q;
    logic             vld_d,  vld_q;

    // Load wins over drain so a channel can stream one word per cycle.
    always_comb begin
        dout_d = dout_q;
        vld_d  = vld_q;
        if (load) begin
            dout_d = din;
            vld_d  = 1'b1;
        end else if (vld_q && rdy) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vld_q  <= vld_d;
        end
    end

    assign dout = dout_q;
    assign vld  = vld_q;

endmodule

// File: rtl/selector14_dist.sv
// ---------------------------------------------------------------------------
// selector14_dist
// Registered 1-to-4 distributor. One valid/ready input stream is routed to
// one of four single-entry channel registers, chosen by {iS1,iS0} (manual)
// or by an internal round-robin pointer (iAuto = 1).
//   iClk, iRst_n       clock, asynchronous active-low reset
//   iData/iValid/oReady input stream handshake
//   iS1, iS0           manual channel select
//   iAuto              1 = round-robin routing, 0 = select pins
//   oC0..oC3/oV0..oV3  channel data and valid
//   iR0..iR3           per-channel consumer ready
//   oPtr               current round-robin pointer
// ---------------------------------------------------------------------------
module selector14_dist
    import selector14_dist_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [WIDTH-1:0] iData,
    input  logic             iValid,
    output logic             oReady,
    input  logic             iS1,
    input  logic             iS0,
    input  logic             iAuto,
    output logic [WIDTH-1:0] oC0,
    output logic [WIDTH-1:0] oC1,
    output logic [WIDTH-1:0] oC2,
    output logic [WIDTH-1:0] oC3,
    output logic             oV0,
    output logic             oV1,
    output logic             oV2,
    output logic             oV3,
    input  logic             iR0,
    input  logic             iR1,
    input  logic             iR2,
    input  logic             iR3,
    output logic [1:0]       oPtr
);

    logic [NCH-1:0][WIDTH-1:0] ch_data;
    logic [NCH-1:0]            ch_vld;
    logic [NCH-1:0]            ch_rdy;
    logic [NCH-1:0]            ch_load;

    logic [1:0] target;
    logic       accept;
    logic [1:0] ptr_d, ptr_q;

    assign ch_rdy = {iR3, iR2, iR1, iR0};

    // Target decode; only the target's own handshake gates the input, so a
    // stalled non-target channel never blocks manual-mode traffic.
    always_comb begin
        target = iAuto ? ptr_q : {iS1, iS0};
        oReady = ~ch_vld[target] | ch_rdy[target];
        accept = iValid & oReady;
    end

    always_comb begin
        ch_load = '0;
        for (int k = 0; k < NCH; k++) begin
            ch_load[k] = accept && (target == k[1:0]);
        end
    end

    // Pointer advances only on accepted words in auto mode; it holds
    // across mode switches.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && iAuto) begin
            ptr_d = rr_next(ptr_q);
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ptr_q <= CH0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        sel_chan_reg #(.WIDTH(WIDTH)) u_chan (
            .clk   (iClk),
            .rst_n (iRst_n),
            .load  (ch_load[g]),
            .din   (iData),
            .rdy   (ch_rdy[g]),
            .dout  (ch_data[g]),
            .vld   (ch_vld[g])
        );
    end

    assign oC0  = ch_data[CH0];
    assign oC1  = ch_data[CH1];
    assign oC2  = ch_data[CH2];
    assign oC3  = ch_data[CH3];
    assign oV0  = ch_vld[CH0];
    assign oV1  = ch_vld[CH1];
    assign oV2  = ch_vld[CH2];
    assign oV3  = ch_vld[CH3];
    assign oPtr = ptr_q;

endmodule

// File: tb/tb_selector14_dist.sv
// ---------------------------------------------------------------------------
// tb_selector14_dist
// Self-checking bench: a queue-free array model of the four channels and
// the pointer is updated on every clock edge from the handshake rules and
// compared with the DUT every falling edge; directed sequences add literal
// expectations; a random phase exercises mixed modes and backpressure.
// ---------------------------------------------------------------------------
module tb_selector14_dist;

    logic       iClk;
    logic       iRst_n;
    logic [3:0] iData;
    logic       iValid;
    logic       oReady;
    logic       iS1, iS0, iAuto;
    logic [3:0] oC0, oC1, oC2, oC3;
    logic       oV0, oV1, oV2, oV3;
    logic [3:0] r;
    logic [1:0] oPtr;

    selector14_dist #(.WIDTH(4)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iData(iData), .iValid(iValid),
        .oReady(oReady), .iS1(iS1), .iS0(iS0), .iAuto(iAuto),
        .oC0(oC0), .oC1(oC1), .oC2(oC2), .oC3(oC3),
        .oV0(oV0), .oV1(oV1), .oV2(oV2), .oV3(oV3),
        .iR0(r[0]), .iR1(r[1]), .iR2(r[2]), .iR3(r[3]),
        .oPtr(oPtr)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // DUT outputs gathered into arrays for indexed comparison
    logic [3:0] c [4];
    logic       v [4];
    assign c[0] = oC0; assign c[1] = oC1; assign c[2] = oC2; assign c[3] = oC3;
    assign v[0] = oV0; assign v[1] = oV1; assign v[2] = oV2; assign v[3] = oV3;

    // ---------------- behavioural model ----------------
    int m_c [4];
    bit m_v [4];
    int m_ptr;

    function automatic int tgt();
        return iAuto ? m_ptr : int'({iS1, iS0});
    endfunction

    function automatic bit m_ready();
        int t = tgt();
        return !m_v[t] || r[t];
    endfunction

    always @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int k = 0; k < 4; k++) begin m_c[k] = 0; m_v[k] = 0; end
            m_ptr = 0;
        end else begin
            int  t;
            bit  acc;
            t   = tgt();
            acc = iValid && m_ready();
            for (int k = 0; k < 4; k++) begin
                if (acc && k == t) begin
                    m_c[k] = int'(iData);
                    m_v[k] = 1;
                end else if (m_v[k] && r[k]) begin
                    m_v[k] = 0;
                end
            end
            if (acc && iAuto) m_ptr = (m_ptr + 1) % 4;
        end
    end

    bit cmp_en = 0;
    always @(negedge iClk) begin
        if (cmp_en && iRst_n) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("model_c%0d", k), int'(c[k]), m_c[k]);
                chk($sformatf("model_v%0d", k), int'(v[k]), int'(m_v[k]));
            end
            chk("model_ptr", int'(oPtr), m_ptr);
            chk("model_ready", int'(oReady), int'(m_ready()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input bit vl, input logic [3:0] d, input bit au,
                         input logic [1:0] s, input logic [3:0] rr);
        iValid = vl; iData = d; iAuto = au; {iS1, iS0} = s; r = rr;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_c%0d", tag, k), int'(c[k]), 0);
            chk($sformatf("%s_v%0d", tag, k), int'(v[k]), 0);
        end
        chk($sformatf("%s_ptr", tag), int'(oPtr), 0);
    endtask

    initial begin
        iRst_n = 1'b0;
        drive(0, 4'h0, 0, 2'b00, 4'b0000);
        #12;
        chk_all_zero("reset");
        @(posedge iClk); #1;
        iRst_n = 1'b1;
        cmp_en = 1;

        // Manual load to channel 2
        drive(1, 4'hA, 0, 2'b10, 4'b0100);
        step();
        drive(0, 4'h0, 0, 2'b10, 4'b0000);
        #2;
        chk("man_c2", int'(oC2), 'hA);
        chk("man_v2", int'(oV2), 1);
        chk("man_v0", int'(oV0), 0);
        chk("man_v1", int'(oV1), 0);
        chk("man_v3", int'(oV3), 0);

        // Backpressure on channel 3
        drive(1, 4'h5, 0, 2'b11, 4'b0000);
        step();
        drive(1, 4'h6, 0, 2'b11, 4'b0000);
        #2;
        chk("bp_ready_low", int'(oReady), 0);
        step();
        chk("bp_hold_c3", int'(oC3), 5);
        chk("bp_hold_v3", int'(oV3), 1);
        r = 4'b1000;
        #1;
        chk("bp_ready_high", int'(oReady), 1);
        step();
        drive(0, 4'h0, 0, 2'b11, 4'b0000);
        #2;
        chk("bp_new_c3", int'(oC3), 6);
        chk("bp_new_v3", int'(oV3), 1);

        // Channel 2 still stalled; manual traffic to channel 0 proceeds
        drive(1, 4'h7, 0, 2'b00, 4'b0000);
        #2;
        chk("nb_v2_stalled", int'(oV2), 1);
        chk("nb_ready", int'(oReady), 1);
        step();
        drive(0, 4'h0, 0, 2'b00, 4'b0000);
        #2;
        chk("nb_c0", int'(oC0), 7);
        chk("nb_v0", int'(oV0), 1);
        chk("nb_c2_kept", int'(oC2), 'hA);

        // Round-robin stream 1..5
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'(i + 1), 1, 2'b00, 4'b1111);
            #2;
            chk($sformatf("rr_ptr%0d", i), int'(oPtr), i % 4);
            step();
            #1;
            chk($sformatf("rr_land%0d", i), int'(c[i % 4]), i + 1);
            chk($sformatf("rr_vld%0d", i), int'(v[i % 4]), 1);
        end
        drive(0, 4'h0, 1, 2'b00, 4'b1111);
        #2;
        chk("rr_ptr_end", int'(oPtr), 1);
        step();

        // Back-to-back throughput to channel 1 (pointer holds in manual mode)
        for (int i = 0; i <= 8; i++) begin
            drive(i < 8, 4'(i), 0, 2'b01, 4'b0010);
            #2;
            if (i < 8) chk($sformatf("b2b_ready%0d", i), int'(oReady), 1);
            if (i > 0) begin
                chk($sformatf("b2b_c1_%0d", i), int'(oC1), i - 1);
                chk($sformatf("b2b_v1_%0d", i), int'(oV1), 1);
            end
            step();
        end
        chk("b2b_ptr_held", int'(oPtr), 1);

        // Random phase
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) == 0,
                  2'($urandom), 4'($urandom));
            step();
        end

        // Asynchronous reset mid-cycle while channel 1 holds a word
        drive(1, 4'h9, 0, 2'b01, 4'b0000);
        step();
        drive(0, 4'h0, 0, 2'b01, 4'b0000);
        #2;
        chk("ar_v1_before", int'(oV1), 1);
        iRst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        step();
        iRst_n = 1'b1;

        for (int n = 0; n < 200; n++) begin
            drive($urandom_range(0, 1), 4'($urandom), $urandom_range(0, 1),
                  2'($urandom), 4'($urandom));
            step();
        end

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
